key_sweep_engine: RTL

Sequential key-search initiator for locked netlists: drives key candidates and input patterns into an equivalence miter and reads back its per-output match vector. Candidates are swept upward from 0 until one key matches the original circuit on every input pattern; the first such key is reported. It sits above the miter wrapper, with `key_out` feeding the locked copy's `lockingkeyinput` and `pat_out` feeding the shared primary inputs. It is the driving end of the miter's compare interface.

---
 rtl/key_sweep_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/key_sweep_engine.sv
// ---------------------------------------------------------------------------
// key_sweep_engine
//
// Brute-force key search driver for a locked-netlist equivalence miter.
// Key candidates are swept upward from 0. Each candidate is held while every
// input pattern is applied in turn. The first key whose miter match vector
// is all ones on every pattern is reported.
//
// Ports
//   C            clock, rising edge
//   R            synchronous active-high reset, clears every register
//   start        begin a sweep (honoured only in IDLE)
//   abort        stop a sweep (honoured only in TEST)
//   match_in     miter per-output equality, 1 = outputs agree
//   key_out      registered key candidate, to the locked copy's key inputs
//   pat_out      registered input pattern, to the shared primary inputs
//   busy         high while in TEST
//   done         one-cycle pulse when a sweep completes
//   found        a matching key was found (held until the next start)
//   key_found    first matching key (held until the next start)
//   cycle_count  TEST evaluations in the last/current sweep, saturating
// ---------------------------------------------------------------------------
module key_sweep_engine #(
    parameter int KEY_W = 5,
    parameter int IN_W  = 5,
    parameter int OUT_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] match_in,
    output logic [KEY_W-1:0] key_out,
    output logic [IN_W-1:0]  pat_out,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [KEY_W-1:0] key_found,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TEST = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [KEY_W-1:0] KEY_MAX = '1;
    localparam logic [IN_W-1:0]  PAT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [IN_W-1:0]  pat_q, pat_d;
    logic             found_q, found_d;
    logic [KEY_W-1:0] key_found_q, key_found_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             all_match;

    // The miter is combinational, so match_in already reflects the
    // key/pattern held during the current cycle.
    assign all_match = &match_in;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        pat_d       = pat_q;
        found_d     = found_q;
        key_found_d = key_found_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d       = '0;
                    pat_d       = '0;
                    found_d     = 1'b0;
                    key_found_d = '0;
                    cnt_d       = '0;
                    state_d     = ST_TEST;
                end
            end

            ST_TEST: begin
                // Every TEST edge is one evaluation, including an aborted one.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (abort) begin
                    state_d = ST_IDLE;
                end else if (all_match) begin
                    if (pat_q != PAT_MAX) begin
                        pat_d = pat_q + 1'b1;
                    end else begin
                        found_d     = 1'b1;
                        key_found_d = key_q;
                        state_d     = ST_DONE;
                    end
                end else begin
                    // A mismatch rejects this key at once; the pattern sweep
                    // restarts for the next candidate.
                    if (key_q != KEY_MAX) begin
                        key_d = key_q + 1'b1;
                        pat_d = '0;
                    end else begin
                        found_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            pat_q       <= '0;
            found_q     <= 1'b0;
            key_found_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            pat_q       <= pat_d;
            found_q     <= found_d;
            key_found_q <= key_found_d;
            cnt_q       <= cnt_d;
        end
    end

    assign key_out     = key_q;
    assign pat_out     = pat_q;
    assign busy        = (state_q == ST_TEST);
    assign done        = (state_q == ST_DONE);
    assign found       = found_q;
    assign key_found   = key_found_q;
    assign cycle_count = cnt_q;

endmodule
